change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream consumer of the vending machine state register: takes the registered balance and pays it out as physical coins when a return is requested.
- Greedy FSM: on each handshake it dispenses the largest coin that fits, choosing from 1000, 500 and 100.
- Reports busy/done to the controller so the balance can be cleared once payout completes.

Parameters:
- TOTAL_BITS, 31, width of balance and remaining-amount buses.
- COIN_HI, 1000, value of the largest coin.
- COIN_MID, 500, value of the middle coin.
- COIN_LO, 100, value of the smallest coin.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk.
- i_return_req  in  1  single-cycle request to start payout.
- current_total  in  TOTAL_BITS  registered balance from the state register.
- i_coin_ready  in  1  coin mechanism can accept a coin this cycle.
- o_coin_valid  out  1  a coin is presented.
- o_coin_sel  out  3  one-hot coin select: bit2=COIN_HI, bit1=COIN_MID, bit0=COIN_LO.
- o_busy  out  1  payout in progress.
- o_done  out  1  one-cycle pulse when payout finishes.
- o_residue  out  1  sticky flag: leftover below COIN_LO was discarded.
- o_remaining  out  TOTAL_BITS  amount still to be paid.

Behaviour:
- Reset: synchronous, active-low. When reset_n=0 at a posedge, all outputs go to 0 and state goes to IDLE. This takes priority over every other event, including mid-payout; no coin transfer is counted on that edge.
- States: IDLE, LOAD, DISPENSE, DONE.
- IDLE:
  - i_return_req=1 → latch current_total into remaining, clear o_residue, go to LOAD.
  - If current_total=0, go directly to DONE instead.
- LOAD:
  - One cycle; o_busy=1.
  - Computes coin select from remaining: COIN_HI if remaining≥COIN_HI, else COIN_MID if ≥COIN_MID, else COIN_LO if ≥COIN_LO.
  - Goes to DISPENSE with o_coin_valid=1 and o_coin_sel registered.
  - If remaining<COIN_LO: set o_residue=1 when remaining≠0, set remaining to 0, go to DONE.
- DISPENSE:
  - o_coin_valid and o_coin_sel hold stable until i_coin_ready=1 is sampled.
  - Transfer on a posedge where valid&&ready: remaining -= selected coin value, o_coin_valid drops to 0, go to LOAD.
  - Result: at most one coin per two cycles; latency from i_return_req to first o_coin_valid is 2 cycles.
- DONE:
  - o_done=1 for exactly one cycle, o_busy=0, then IDLE.
- o_busy=1 in LOAD and DISPENSE only.
- i_return_req outside IDLE is ignored; no queueing.
- current_total changes during payout are ignored because the amount was latched.
- Arithmetic is unsigned at TOTAL_BITS. Subtraction never underflows because selection guarantees remaining≥coin.
- o_remaining reflects the registered remaining value every cycle and is 0 in IDLE after reset.
- o_residue stays set until the next accepted i_return_req or reset.

Optional Feature:
- Macro: CHANGE_DISPENSER_STATS_EN.
- When defined: adds outputs o_cnt_hi, o_cnt_mid, o_cnt_lo (16 bits each), counting coins transferred per denomination since reset.
  - Each counter increments on the valid&&ready edge and saturates at 16'hFFFF.
  - Counters reset to 0 and are not cleared by a new payout.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- current_total=1600, return_req, ready always 1 → coins HI, MID, LO in order; o_done pulse; remaining 1600→600→100→0; o_residue=0.
- current_total=0, return_req → no o_coin_valid; o_done one cycle after request; o_busy never 1.
- current_total=250, ready=0 for 5 cycles then 1 → MID is never selected; LO held stable 5 cycles; two LO transfers; residue 50 dropped; o_residue=1; remaining=0.
- current_total=2000, return_req; current_total forced to 100 and second return_req mid-payout → both ignored; two HI coins paid.
- Payout of 1500 with reset_n=0 after the first HI transfer → next edge all outputs 0, IDLE, no further coins; stats counters (if enabled) read 0.
- With CHANGE_DISPENSER_STATS_EN, two payouts of 1600 → o_cnt_hi=2, o_cnt_mid=2, o_cnt_lo=2.

Source files
------------

// File: rtl/change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : change_dispenser                                           |
// | Description : Greedy coin payout engine. On a return request it latches  |
// |               the registered balance and pays it out one coin per        |
// |               valid/ready handshake, largest fitting denomination first  |
// |               (COIN_HI, COIN_MID, COIN_LO). Any amount below COIN_LO is  |
// |               discarded and flagged on o_residue.                        |
// | Ports       : clk, reset_n       - clock, synchronous active-low reset   |
// |               i_return_req       - one-cycle payout request              |
// |               current_total      - balance to pay out (latched)          |
// |               i_coin_ready       - coin mechanism accepts a coin         |
// |               o_coin_valid/_sel  - coin presented, one-hot {HI,MID,LO}   |
// |               o_busy, o_done     - payout in progress / finished pulse   |
// |               o_residue          - sub-COIN_LO leftover was dropped      |
// |               o_remaining        - amount still to be paid               |
// | Options     : CHANGE_DISPENSER_STATS_EN adds o_cnt_hi/_mid/_lo, 16-bit   |
// |               saturating per-denomination coin counters.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int COIN_HI    = 1000,
  parameter int COIN_MID   = 500,
  parameter int COIN_LO    = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_return_req,
  input  logic [TOTAL_BITS-1:0] current_total,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [2:0]            o_coin_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_residue,
`ifdef CHANGE_DISPENSER_STATS_EN
  output logic [15:0]           o_cnt_hi,
  output logic [15:0]           o_cnt_mid,
  output logic [15:0]           o_cnt_lo,
`endif
  output logic [TOTAL_BITS-1:0] o_remaining
);

  localparam logic [TOTAL_BITS-1:0] C_COIN_HI  = TOTAL_BITS'(COIN_HI);
  localparam logic [TOTAL_BITS-1:0] C_COIN_MID = TOTAL_BITS'(COIN_MID);
  localparam logic [TOTAL_BITS-1:0] C_COIN_LO  = TOTAL_BITS'(COIN_LO);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_DISPENSE = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e                  state_q,     state_d;
  logic [TOTAL_BITS-1:0]   remaining_q, remaining_d;
  logic                    residue_q,   residue_d;
  logic                    valid_q,     valid_d;
  logic [2:0]              sel_q,       sel_d;
  logic [TOTAL_BITS-1:0]   w_coin_val;

  // Value of the coin currently presented; selection guarantees it fits.
  always_comb begin
    w_coin_val = '0;
    if (sel_q[2])      w_coin_val = C_COIN_HI;
    else if (sel_q[1]) w_coin_val = C_COIN_MID;
    else if (sel_q[0]) w_coin_val = C_COIN_LO;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    residue_d   = residue_q;
    valid_d     = valid_q;
    sel_d       = sel_q;
    case (state_q)
      S_IDLE: begin
        if (i_return_req) begin
          remaining_d = current_total;
          residue_d   = 1'b0;
          state_d     = (current_total == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (remaining_q >= C_COIN_HI)       sel_d = 3'b100;
        else if (remaining_q >= C_COIN_MID) sel_d = 3'b010;
        else                                sel_d = 3'b001;
        if (remaining_q >= C_COIN_LO) begin
          valid_d = 1'b1;
          state_d = S_DISPENSE;
        end else begin
          // Nothing payable is left; drop the remainder and flag it.
          sel_d       = 3'b000;
          residue_d   = (remaining_q != '0);
          remaining_d = '0;
          state_d     = S_DONE;
        end
      end
      S_DISPENSE: begin
        if (valid_q && i_coin_ready) begin
          remaining_d = remaining_q - w_coin_val;
          valid_d     = 1'b0;
          sel_d       = 3'b000;
          state_d     = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      residue_q   <= 1'b0;
      valid_q     <= 1'b0;
      sel_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residue_q   <= residue_d;
      valid_q     <= valid_d;
      sel_q       <= sel_d;
    end
  end

  assign o_coin_valid = valid_q;
  assign o_coin_sel   = sel_q;
  assign o_busy       = (state_q == S_LOAD) || (state_q == S_DISPENSE);
  assign o_done       = (state_q == S_DONE);
  assign o_residue    = residue_q;
  assign o_remaining  = remaining_q;

`ifdef CHANGE_DISPENSER_STATS_EN
  logic        w_xfer;
  logic [15:0] cnt_hi_q,  cnt_hi_d;
  logic [15:0] cnt_mid_q, cnt_mid_d;
  logic [15:0] cnt_lo_q,  cnt_lo_d;

  assign w_xfer = (state_q == S_DISPENSE) && valid_q && i_coin_ready;

  // Counters span all payouts since reset and stick at full scale.
  always_comb begin
    cnt_hi_d  = cnt_hi_q;
    cnt_mid_d = cnt_mid_q;
    cnt_lo_d  = cnt_lo_q;
    if (w_xfer && sel_q[2] && (cnt_hi_q  != 16'hFFFF)) cnt_hi_d  = cnt_hi_q  + 16'd1;
    if (w_xfer && sel_q[1] && (cnt_mid_q != 16'hFFFF)) cnt_mid_d = cnt_mid_q + 16'd1;
    if (w_xfer && sel_q[0] && (cnt_lo_q  != 16'hFFFF)) cnt_lo_d  = cnt_lo_q  + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_hi_q  <= 16'd0;
      cnt_mid_q <= 16'd0;
      cnt_lo_q  <= 16'd0;
    end else begin
      cnt_hi_q  <= cnt_hi_d;
      cnt_mid_q <= cnt_mid_d;
      cnt_lo_q  <= cnt_lo_d;
    end
  end

  assign o_cnt_hi  = cnt_hi_q;
  assign o_cnt_mid = cnt_mid_q;
  assign o_cnt_lo  = cnt_lo_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_change_dispenser                                        |
// | Description : Self-checking bench for change_dispenser. Each request     |
// |               pushes the expected coin sequence and end-of-payout        |
// |               status into queues; a negedge monitor pops and compares    |
// |               on every coin transfer and every done pulse.               |
// | Options     : CHANGE_DISPENSER_STATS_EN also checks the coin counters.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_change_dispenser;

  localparam int TOTAL_BITS = 31;
  localparam int COIN_HI    = 1000;
  localparam int COIN_MID   = 500;
  localparam int COIN_LO    = 100;

  logic                  clk;
  logic                  reset_n;
  logic                  i_return_req;
  logic [TOTAL_BITS-1:0] current_total;
  logic                  i_coin_ready;
  logic                  o_coin_valid;
  logic [2:0]            o_coin_sel;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_residue;
  logic [TOTAL_BITS-1:0] o_remaining;
`ifdef CHANGE_DISPENSER_STATS_EN
  logic [15:0]           o_cnt_hi;
  logic [15:0]           o_cnt_mid;
  logic [15:0]           o_cnt_lo;
`endif

  change_dispenser #(
    .TOTAL_BITS (TOTAL_BITS),
    .COIN_HI    (COIN_HI),
    .COIN_MID   (COIN_MID),
    .COIN_LO    (COIN_LO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_return_req  (i_return_req),
    .current_total (current_total),
    .i_coin_ready  (i_coin_ready),
    .o_coin_valid  (o_coin_valid),
    .o_coin_sel    (o_coin_sel),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_residue     (o_residue),
`ifdef CHANGE_DISPENSER_STATS_EN
    .o_cnt_hi      (o_cnt_hi),
    .o_cnt_mid     (o_cnt_mid),
    .o_cnt_lo      (o_cnt_lo),
`endif
    .o_remaining   (o_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues filled by the reference model.
  int exp_sel_q[$];
  int exp_rem_q[$];
  bit exp_res_q[$];

  // Expected per-denomination totals since reset.
  int exp_cnt_hi = 0, exp_cnt_mid = 0, exp_cnt_lo = 0;

  // Greedy payout from plain arithmetic: largest coin that fits, repeatedly.
  function automatic void model_push(input int amt);
    int cur;
    cur = amt;
    while (cur >= COIN_HI)  begin exp_sel_q.push_back(4); exp_rem_q.push_back(cur); cur -= COIN_HI;  end
    while (cur >= COIN_MID) begin exp_sel_q.push_back(2); exp_rem_q.push_back(cur); cur -= COIN_MID; end
    while (cur >= COIN_LO)  begin exp_sel_q.push_back(1); exp_rem_q.push_back(cur); cur -= COIN_LO;  end
    exp_res_q.push_back(cur != 0);
  endfunction

  // Monitor state
  int first_valid_cyc = -1;
  int done_cyc        = -1;
  int done_cnt        = 0;
  int n_xfer          = 0;
  bit busy_seen       = 0;
  bit hold_pending    = 0;
  bit prev_done       = 0;
  logic [2:0] held_sel = 3'b000;

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_busy) busy_seen = 1'b1;
      if (o_coin_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (hold_pending) check("sel_stable", o_coin_sel, held_sel);
        if (i_coin_ready) begin
          if (exp_sel_q.size() == 0) begin
            check("unexpected_coin", 1, 0);
          end else begin
            int es, er;
            es = exp_sel_q.pop_front();
            er = exp_rem_q.pop_front();
            check("coin_sel", o_coin_sel, es);
            check("remaining_before_coin", o_remaining, er);
            if (es == 4) exp_cnt_hi++;
            if (es == 2) exp_cnt_mid++;
            if (es == 1) exp_cnt_lo++;
          end
          n_xfer++;
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          held_sel     = o_coin_sel;
        end
      end
      if (o_done) begin
        check("done_single_cycle", prev_done, 0);
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          bit er;
          er = exp_res_q.pop_front();
          check("residue", o_residue, er);
        end
        check("remaining_at_done", o_remaining, 0);
        check("busy_at_done", o_busy, 0);
        check("coins_outstanding_at_done", exp_sel_q.size(), 0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = o_done;
    end
  end

  // mode 0: ready always 1; mode 1: random ready; mode 2: ready low for the
  // first cycles so the first coin is held, then 1.
  // inject_at > 0: re-request with a different balance mid-payout.
  task automatic payout(input int amt, input int mode, input int inject_at, output int issue_cyc);
    int done_before;
    @(posedge clk); #1;
    issue_cyc       = cyc;
    done_before     = done_cnt;
    first_valid_cyc = -1;
    busy_seen       = 1'b0;
    model_push(amt);
    current_total   = TOTAL_BITS'(amt);
    i_return_req    = 1'b1;
    i_coin_ready    = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
    for (int c = 0; c < 300 && done_cnt == done_before; c++) begin
      @(posedge clk); #1;
      i_return_req = (inject_at > 0) && (c + 1 == inject_at);
      if (i_return_req) current_total = TOTAL_BITS'(COIN_LO);
      case (mode)
        0:       i_coin_ready = 1'b1;
        1:       i_coin_ready = 1'($urandom_range(0, 1));
        default: i_coin_ready = (c >= 6);
      endcase
    end
    if (done_cnt == done_before) check("payout_timeout", 1, 0);
    i_return_req = 1'b0;
  endtask

  task automatic check_stats();
`ifdef CHANGE_DISPENSER_STATS_EN
    check("cnt_hi",  o_cnt_hi,  exp_cnt_hi);
    check("cnt_mid", o_cnt_mid, exp_cnt_mid);
    check("cnt_lo",  o_cnt_lo,  exp_cnt_lo);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},     o_coin_valid, 0);
    check({tag, "_sel"},       o_coin_sel,   0);
    check({tag, "_busy"},      o_busy,       0);
    check({tag, "_done"},      o_done,       0);
    check({tag, "_residue"},   o_residue,    0);
    check({tag, "_remaining"}, o_remaining,  0);
  endtask

  initial begin
    int ic;
    int xb;
    reset_n       = 1'b0;
    i_return_req  = 1'b0;
    current_total = '0;
    i_coin_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check_stats();
    reset_n = 1'b1;

    // 1600 -> HI, MID, LO with first coin two cycles after the request.
    payout(1600, 0, 0, ic);
    check("latency_first_coin", first_valid_cyc - ic, 2);

    // Zero balance: straight to done, never busy, no coins.
    payout(0, 0, 0, ic);
    check("zero_done_latency", done_cyc - ic, 1);
    check("zero_never_busy", busy_seen, 0);

    // 250 with a stalled mechanism: LO held, two LO coins, 50 dropped.
    payout(250, 2, 0, ic);
    check("residue_sticky_after_250", o_residue, 1);

    // 2000 with a mid-payout re-request and changed balance: both ignored.
    payout(2000, 0, 4, ic);
    check("residue_cleared_by_new_req", o_residue, 0);

    // Random balances and random backpressure.
    for (int i = 0; i < 20; i++) begin
      payout(int'($urandom_range(0, 4000)), 1, 0, ic);
    end
    check_stats();

    // Two payouts of 1600 accumulate in the counters.
    payout(1600, 0, 0, ic);
    payout(1600, 1, 0, ic);
    check_stats();

    // Reset mid-payout right after the first HI coin of 1500.
    @(posedge clk); #1;
    xb = n_xfer;
    model_push(1500);
    current_total = TOTAL_BITS'(1500);
    i_return_req  = 1'b1;
    i_coin_ready  = 1'b1;
    for (int c = 0; c < 50 && n_xfer == xb; c++) begin
      @(posedge clk); #1;
      i_return_req = 1'b0;
    end
    check("reset_test_first_coin_seen", n_xfer - xb, 1);
    reset_n      = 1'b0;
    i_coin_ready = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    exp_sel_q.delete();
    exp_rem_q.delete();
    exp_res_q.delete();
    exp_cnt_hi   = 0;
    exp_cnt_mid  = 0;
    exp_cnt_lo   = 0;
    hold_pending = 1'b0;
    prev_done    = 1'b0;
    check_stats();
    reset_n      = 1'b1;
    i_coin_ready = 1'b1;
    xb = n_xfer;
    repeat (4) @(posedge clk);
    #1;
    check("no_coins_after_reset", n_xfer - xb, 0);
    check_all_zero("post_reset_idle");
    check_stats();

    check("scoreboard_empty", exp_sel_q.size() + exp_res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
